// File: rtl/vedic_mult4x4_seq.sv
// Sequential 4x4 unsigned multiplier. A single 2x2 Vedic cell is stepped over
// the four 2-bit slice pairs of the latched operands, and the shifted partial
// products are summed into an 8-bit accumulator. Valid/ready on both sides.
module vedic_mult4x4_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] y,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  step;
  logic [3:0]  a_r;
  logic [3:0]  b_r;
  logic [7:0]  acc;
  logic [1:0]  slice_a;
  logic [1:0]  slice_b;
  logic [3:0]  pp;
  logic [7:0]  term;

  // Slice select: step[0] picks the high half of a, step[1] the high half of b,
  // so steps 0..3 walk lo*lo, hi*lo, lo*hi, hi*hi.
  always_comb begin
    slice_a = step[0] ? a_r[3:2] : a_r[1:0];
    slice_b = step[1] ? b_r[3:2] : b_r[1:0];
  end

  vedicMult2x2 u_cell (
    .a (slice_a),
    .b (slice_b),
    .p (pp)
  );

  // Align the 4-bit partial product by the combined slice weight.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    term = {4'b0000, pp};
    case (step)
      2'd1, 2'd2: term = {2'b00, pp, 2'b00};
      2'd3:       term = {pp, 4'b0000};
      default:    term = {4'b0000, pp};
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (step == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latch, slice counter, accumulator and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= 4'd0;
      b_r  <= 4'd0;
      acc  <= 8'd0;
      step <= 2'd0;
      y    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r  <= a;
            b_r  <= b;
            acc  <= 8'd0;
            step <= 2'd0;
          end
        end
        CALC: begin
          // 15*15 = 225 fits in 8 bits, so the sum never wraps.
          acc  <= acc + term;
          step <= step + 2'd1;
          if (step == 2'd3) y <= acc + term;
        end
        default: ;
      endcase
    end
  end

endmodule

// 2x2 Vedic (Urdhva Tiryagbhyam) multiplier cell: vertical and crosswise
// bit products combined with two half-adder stages.
module vedicMult2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic cross_lo;
  logic cross_hi;
  logic vert_hi;
  logic carry;

  assign cross_lo = a[1] & b[0];
  assign cross_hi = a[0] & b[1];
  assign vert_hi  = a[1] & b[1];
  assign carry    = cross_lo & cross_hi;

  assign p[0] = a[0] & b[0];
  assign p[1] = cross_lo ^ cross_hi;
  assign p[2] = vert_hi ^ carry;
  assign p[3] = vert_hi & carry;

endmodule

// File: tb/tb_vedic_mult4x4_seq.sv
// Bench for vedic_mult4x4_seq: a cycle-level transaction model (accept,
// four-cycle latency, hold under backpressure) is compared against the DUT on
// every falling edge, and directed literal checks pin the model's results.
module tb_vedic_mult4x4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       busy;

  logic       fixed_ready;
  logic       rand_mode;
  logic       rnd_bit;
  logic       cmp_en;

  int checks   = 0;
  int failures = 0;

  // Model: 0 = waiting for operands, 1..4 = computing, 5 = result held.
  int         m_cnt  = 0;
  logic [7:0] m_prod = 8'd0;
  logic [7:0] m_y    = 8'd0;
  int         cyc    = 0;
  int         acc_cyc[$];
  int         done_cyc[$];
  logic [7:0] done_q[$];

  vedic_mult4x4_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign out_ready = rand_mode ? rnd_bit : fixed_ready;

  // Random downstream stalls, changed away from the active edge.
  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Transaction-level reference: a*b appears 4 edges after acceptance and is
  // held until a cycle with out_ready; reset abandons everything.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_cnt <= 0;
      m_y   <= 8'd0;
    end else if (m_cnt == 0) begin
      if (in_valid) begin
        m_prod <= 8'({4'd0, a} * {4'd0, b});
        m_cnt  <= 1;
        acc_cyc.push_back(cyc);
      end
    end else if (m_cnt < 4) begin
      m_cnt <= m_cnt + 1;
    end else if (m_cnt == 4) begin
      m_y   <= m_prod;
      m_cnt <= 5;
      done_cyc.push_back(cyc);
    end else if (out_ready) begin
      m_cnt <= 0;
      done_q.push_back(m_y);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_in_ready",  32'(in_ready),  32'(m_cnt == 0));
      check("cyc_out_valid", 32'(out_valid), 32'(m_cnt == 5));
      check("cyc_busy",      32'(busy),      32'(m_cnt != 0));
      check("cyc_y",         32'(y),         32'(m_y));
    end
  end

  // Called at a falling edge; waits (bounded) for in_ready, then presents one
  // operand pair for exactly one rising edge.
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int guard = 0;
    while (done_q.size() < n && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (done_q.size() < n) check("drain_timeout", 32'(done_q.size()), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst         = 1'b1;
    in_valid    = 1'b0;
    a           = 4'd0;
    b           = 4'd0;
    fixed_ready = 1'b1;
    rand_mode   = 1'b0;
    cmp_en      = 1'b0;

    // 1: reset for two edges
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_y",         32'(y),         32'h00);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    cmp_en = 1'b1;

    // 2: maximum operands, 4-cycle latency
    do_op(4'd15, 4'd15);
    wait_done(1);
    check("max_y", 32'(done_q[0]), 32'd225);
    check("max_latency", 32'(done_cyc[0] - acc_cyc[0]), 32'd4);

    // 3: back-to-back operations at full throughput
    base = acc_cyc.size();
    do_op(4'd10, 4'd6);
    do_op(4'd0,  4'd13);
    do_op(4'd1,  4'd1);
    wait_done(4);
    check("b2b_y0", 32'(done_q[1]), 32'd60);
    check("b2b_y1", 32'(done_q[2]), 32'd0);
    check("b2b_y2", 32'(done_q[3]), 32'd1);
    check("b2b_gap0", 32'(acc_cyc[base+1] - acc_cyc[base]),   32'd6);
    check("b2b_gap1", 32'(acc_cyc[base+2] - acc_cyc[base+1]), 32'd6);

    // 4: backpressure holds the result; new operands wait for the drain
    fixed_ready = 1'b0;
    do_op(4'd7, 4'd9);
    repeat (4) @(negedge clk);
    a        = 4'd3;
    b        = 4'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_y",         32'(y),         32'd63);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
    end
    fixed_ready = 1'b1;
    begin
      int guard = 0;
      while (!in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("bp_reaccept", 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(6);
    check("bp_y_held", 32'(done_q[4]), 32'd63);
    check("bp_y_next", 32'(done_q[5]), 32'd9);

    // 5: reset mid-computation discards the product
    do_op(4'd12, 4'd5);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_y",         32'(y),         32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_no_result", 32'(done_q.size()), 32'd6);

    // 6: exhaustive sweep with random output stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        do_op(4'(i), 4'(j));
    wait_done(6 + 256);
    check("sweep_count", 32'(done_q.size()), 32'd262);
    for (int k = 0; k < 256 && k + 6 < done_q.size(); k++)
      if (done_q[k+6] != 8'((k / 16) * (k % 16)))
        check("sweep_model", 32'(done_q[k+6]), 32'((k / 16) * (k % 16)));

    rand_mode = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vedic_mult4x4_seq.md
Name: vedic_mult4x4_seq

Overview:
Sequential 4x4 unsigned multiplier built around a single instance of the team's 2x2 Vedic multiplier cell (vedicMult2x2). It sits directly downstream of that cell and consumes its 4-bit products. It time-multiplexes the cell over four 2-bit operand slices and accumulates the shifted partial products into an 8-bit result. Operands and results move over valid/ready handshakes so the block can sit between register stages of a datapath.

Parameters:
none (fixed 4x4 -> 8 configuration; the slice width is set by the 2x2 cell)

Ports:
clk        input   1  system clock, all state updates on rising edge
rst        input   1  reset; synchronous, active-high
in_valid   input   1  operand pair a/b is valid
in_ready   output  1  block can accept operands (high only in IDLE)
a          input   4  multiplicand, unsigned
b          input   4  multiplier, unsigned
out_valid  output  1  y holds a completed product
out_ready  input   1  downstream accepts y
y          output  8  product a*b, unsigned
busy       output  1  high in CALC or DONE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, step=0, acc=0, a_r=b_r=0, y=0, out_valid=0, busy=0, in_ready=1 after the edge. rst overrides all other inputs, including mid-CALC or DONE; any in-flight product is discarded.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1: latch a_r=a and b_r=b, clear acc=0, step=0, go to CALC. If in_valid=0, stay in IDLE.
- CALC: in_ready=0 and busy=1. Each edge feeds one slice pair to the 2x2 cell (combinational) and adds its product, zero-extended and shifted, into acc. Then step increments.
  - step0: a_r[1:0]*b_r[1:0], shift 0
  - step1: a_r[3:2]*b_r[1:0], shift 2
  - step2: a_r[1:0]*b_r[3:2], shift 2
  - step3: a_r[3:2]*b_r[3:2], shift 4; y <= acc+term, go to DONE
- Accumulator rules: acc is 8 bits wide and never overflows, because the maximum is 15*15=225.
- DONE: out_valid=1, in_ready=0, and y is held stable.
  - On an edge with out_ready=1: out_valid=0 and state goes to IDLE.
  - y keeps its last value until the next completion.
  - out_ready=0 holds DONE indefinitely (backpressure).
- Latency: after the accept edge E0, steps run on E1..E4 and out_valid is high immediately after E4 (4 cycles).
- Throughput: minimum spacing between accept edges is 6 cycles (E5 drains with out_ready=1, E6 is the next accept). There is no overlap of operations.
- Operand handling:
  - in_valid asserted while in_ready=0 is ignored; operands are not queued, and the upstream must hold them.
  - a/b changes after the accept edge do not affect the result.
- Handshake stability: out_ready is ignored outside DONE. out_valid never drops without out_ready=1, except on rst.
- Datapath: only one 2x2 cell is instantiated; the slice selection muxes are driven by step.

Test Plan:
1. rst=1 for 2 edges, then release -> y=0x00, out_valid=0, in_ready=1, busy=0.
2. a=15, b=15, in_valid pulse, out_ready=1 -> out_valid rises 4 cycles after accept with y=225 (0xE1); in_ready=1 one cycle after the drain edge.
3. a=10, b=6, then a=0, b=13, then a=1, b=1, issued back-to-back as soon as in_ready allows -> y=60, 0, 1 in order, with 6-cycle spacing between accepts.
4. a=7, b=9 with out_ready=0 for 10 cycles -> out_valid stays 1 and y=63 stable throughout. in_valid=1 with a=3, b=3 during this time is not accepted (in_ready=0). Raising out_ready completes the drain, then a=3, b=3 is accepted -> y=9.
5. a=12, b=5 accepted, rst=1 asserted after step1 -> next edge: state IDLE, out_valid=0, y=0. No 60 ever appears on y.
6. Exhaustive sweep of all 256 a/b pairs with random out_ready stalls -> every y equals a*b, and out_valid/y never change while out_valid=1 and out_ready=0.
